seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 33 +++
 rtl/bcd_sev_seg_dec.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment scan controller:
//   - NUM_DGT        : number of display digits (fixed at 5)
//   - dgt_idx_t      : type of the digit index (0..NUM_DGT-1)
//   - SEG_0..SEG_9   : segment codes {dp,g,f,e,d,c,b,a}, active-high
//   - SEG_OFF        : all segments dark
//   - dgt_onehot()   : digit index -> one-hot digit enable
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DGT = 5;

    typedef logic [2:0] dgt_idx_t;

    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Bit i of the result enables digit i; bit 0 is the rightmost digit.
    function automatic logic [NUM_DGT-1:0] dgt_onehot(input dgt_idx_t idx);
        return NUM_DGT'(1) << idx;
    endfunction

endpackage

// File: rtl/bcd_sev_seg_dec.sv
// -----------------------------------------------------------------------------
// bcd_sev_seg_dec
// Purely combinational BCD to seven-segment decoder.
// Ports:
//   bcd  in  [3:0]  digit value; 0..9 are decoded, 10..15 give all segments off
//   seg  out [7:0]  segments {dp,g,f,e,d,c,b,a}, active-high, dp always 0
// -----------------------------------------------------------------------------
module bcd_sev_seg_dec (
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    import seg_pkg::*;

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 5-digit common-select seven-segment
// display. Software writes BCD digits into a shadow bank and requests a
// commit; the shadow bank is copied to the live bank only at a frame
// boundary so a frame is never shown half old / half new.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (4..2^20)
//   NUM_DGT    number of digits (fixed at 5)
//
// Ports:
//   clk         in         system clock, rising edge
//   rst_n       in         asynchronous active-low reset
//   wr_en       in         write wr_data into shadow digit wr_idx (when wr_rdy)
//   wr_idx      in  [2:0]  shadow digit index 0..4; 5..7 are dropped
//   wr_data     in  [3:0]  BCD value to write
//   wr_rdy      out        high while writes / commits are accepted
//   commit      in         request shadow -> live copy at next frame boundary
//   blank       in         forces all digits dark while high
//   dgt_slct    out [4:0]  one-hot digit enable, bit 0 = rightmost digit
//   data_out    out [7:0]  segments {dp,g,f,e,d,c,b,a}, active-high
//   frame_done  out        one-cycle pulse on the last cycle of digit 4's slot
//
// Build option:
//   SEG_LZB_EN  when defined, leading zeros (digits 1..4) are blanked.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int NUM_DGT  = seg_pkg::NUM_DGT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_idx,
    input  logic [3:0]         wr_data,
    output logic               wr_rdy,
    input  logic               commit,
    input  logic               blank,
    output logic [NUM_DGT-1:0] dgt_slct,
    output logic [7:0]         data_out,
    output logic               frame_done
);

    import seg_pkg::*;

    localparam int       PW       = $clog2(SCAN_DIV);
    localparam dgt_idx_t LAST_DGT = dgt_idx_t'(NUM_DGT - 1);

    logic [PW-1:0]            presc;
    dgt_idx_t                 idx;
    logic                     tc;
    logic                     tc_last;
    logic                     frame_pre;

    logic [NUM_DGT-1:0][3:0]  shadow;
    logic [NUM_DGT-1:0][3:0]  live;
    logic                     commit_pend;

    logic [3:0]               cur_digit;
    logic [7:0]               seg_raw;
    logic                     lzb_mask;
    logic                     show;

    assign tc      = (presc == PW'(SCAN_DIV - 1));
    assign tc_last = tc && (idx == LAST_DGT);

    // frame_done is a flop; it is loaded one cycle early so that it is high
    // exactly during the terminal-count cycle of digit 4's slot.
    assign frame_pre = (presc == PW'(SCAN_DIV - 2)) && (idx == LAST_DGT);

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= (idx == LAST_DGT) ? dgt_idx_t'(0) : idx + dgt_idx_t'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Shadow bank and commit handshake. While a commit is pending the
    // interface is closed, so the copy at the frame boundary always sees a
    // stable shadow bank. A write in the same cycle as the commit request
    // lands in the shadow bank before the copy happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            live        <= '0;
            commit_pend <= 1'b0;
        end else if (commit_pend) begin
            if (tc_last) begin
                live        <= shadow;
                commit_pend <= 1'b0;
            end
        end else begin
            if (wr_en && (wr_idx < 3'(NUM_DGT))) begin
                shadow[wr_idx] <= wr_data;
            end
            if (commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

    assign wr_rdy = !commit_pend;

    assign cur_digit = live[idx];

    bcd_sev_seg_dec u_dec (
        .bcd (cur_digit),
        .seg (seg_raw)
    );

`ifdef SEG_LZB_EN
    // lead_zero[i] is set when live digits i..4 are all zero.
    logic [NUM_DGT-1:0] lead_zero;

    always_comb begin
        lead_zero = '1;
        for (int i = 0; i < NUM_DGT; i++) begin
            for (int j = i; j < NUM_DGT; j++) begin
                if (live[j] != 4'd0) begin
                    lead_zero[i] = 1'b0;
                end
            end
        end
    end

    // Digit 0 always shows, so a zero value still displays "0".
    assign lzb_mask = (idx != dgt_idx_t'(0)) && lead_zero[idx];
`else
    assign lzb_mask = 1'b0;
`endif

    // The first cycle of each slot is kept dark so the previous digit's
    // segments never flash on the newly selected digit.
    assign show = !blank && (presc != '0);

    // Select and segment outputs are registered together so they change on
    // the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dgt_slct   <= '0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            dgt_slct   <= show ? dgt_onehot(idx) : '0;
            data_out   <= (show && !lzb_mask) ? seg_raw : SEG_OFF;
            frame_done <= frame_pre;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=4 (20-cycle frame).
// A hand-written table covers the first frames after reset (including a
// blank stretch); later sequences use a cycle-count based expectation of the
// scan plus a shadow/live bookkeeping of the writes and commits.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic       wr_rdy;
    logic       commit;
    logic       blank;
    logic [4:0] dgt_slct;
    logic [7:0] data_out;
    logic       frame_done;

    seg_scan_ctrl #(.SCAN_DIV(DIV), .NUM_DGT(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_rdy     (wr_rdy),
        .commit     (commit),
        .blank      (blank),
        .dgt_slct   (dgt_slct),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Edges since reset release; also the scan position before the next edge.
    int         n;
    logic [3:0] sh_exp [5];
    logic [3:0] lv_exp [5];
    bit         pend_exp;

    logic [4:0] e_slct;
    logic [7:0] e_data;
    logic       e_frame;
    logic       e_rdy;

    typedef struct {
        logic       blank;
        logic [4:0] slct;
        logic [7:0] data;
        logic       frame;
    } vec_t;

    vec_t tab [28];

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic modelReset();
        n        = 0;
        pend_exp = 0;
        for (int i = 0; i < 5; i++) begin
            sh_exp[i] = 4'd0;
            lv_exp[i] = 4'd0;
        end
    endtask

    // Drive one cycle of inputs, let one rising edge happen, update the
    // expected outputs, and return at the following falling edge.
    task automatic applyStimulus(input logic we, input logic [2:0] idx, input logic [3:0] data,
                                 input logic cm, input logic bl);
        int   c, p, d;
        logic rdy, act, lzb;
        wr_en   = we;
        wr_idx  = idx;
        wr_data = data;
        commit  = cm;
        blank   = bl;
        @(posedge clk);
        c = n;
        n++;
        p   = c % DIV;
        d   = (c / DIV) % 5;
        act = !bl && (p != 0);
        lzb = 1'b0;
`ifdef SEG_LZB_EN
        lzb = (d != 0);
        for (int j = d; j < 5; j++) if (lv_exp[j] != 4'd0) lzb = 1'b0;
`endif
        e_slct  = act ? 5'(1 << d) : 5'd0;
        e_data  = (act && !lzb) ? seg_of(lv_exp[d]) : 8'h00;
        e_frame = ((c % (5 * DIV)) == (5 * DIV - 2));
        rdy = !pend_exp;
        if (pend_exp && ((c % (5 * DIV)) == (5 * DIV - 1))) begin
            for (int i = 0; i < 5; i++) lv_exp[i] = sh_exp[i];
            pend_exp = 0;
        end else if (rdy) begin
            if (we && idx < 3'd5) sh_exp[idx] = data;
            if (cm) pend_exp = 1;
        end
        e_rdy = !pend_exp;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".slct"},  {3'b000, dgt_slct}, {3'b000, e_slct});
        cmp({tag, ".data"},  data_out,            e_data);
        cmp({tag, ".frame"}, {7'd0, frame_done},  {7'd0, e_frame});
        cmp({tag, ".rdy"},   {7'd0, wr_rdy},      {7'd0, e_rdy});
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
            checkOutput(tag);
        end
    endtask

    // Bounded wait for the pending commit to be released.
    task automatic waitRdy(input string tag);
        for (int k = 0; k < 45 && !wr_rdy; k++) begin
            applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
            checkOutput(tag);
        end
        cmp({tag, ".rdy_back"}, {7'd0, wr_rdy}, 8'd1);
        cmp({tag, ".boundary"}, 8'(n % (5 * DIV)), 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tab[0]  = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[1]  = '{1'b0, 5'b00001, 8'h3F, 1'b0};
        tab[2]  = '{1'b0, 5'b00001, 8'h3F, 1'b0};
        tab[3]  = '{1'b0, 5'b00001, 8'h3F, 1'b0};
        tab[4]  = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[5]  = '{1'b0, 5'b00010, 8'h3F, 1'b0};
        tab[6]  = '{1'b0, 5'b00010, 8'h3F, 1'b0};
        tab[7]  = '{1'b0, 5'b00010, 8'h3F, 1'b0};
        tab[8]  = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[9]  = '{1'b0, 5'b00100, 8'h3F, 1'b0};
        tab[10] = '{1'b0, 5'b00100, 8'h3F, 1'b0};
        tab[11] = '{1'b0, 5'b00100, 8'h3F, 1'b0};
        tab[12] = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[13] = '{1'b0, 5'b01000, 8'h3F, 1'b0};
        tab[14] = '{1'b0, 5'b01000, 8'h3F, 1'b0};
        tab[15] = '{1'b0, 5'b01000, 8'h3F, 1'b0};
        tab[16] = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[17] = '{1'b0, 5'b10000, 8'h3F, 1'b0};
        tab[18] = '{1'b0, 5'b10000, 8'h3F, 1'b1};
        tab[19] = '{1'b0, 5'b10000, 8'h3F, 1'b0};
        tab[20] = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[21] = '{1'b1, 5'b00000, 8'h00, 1'b0};
        tab[22] = '{1'b1, 5'b00000, 8'h00, 1'b0};
        tab[23] = '{1'b1, 5'b00000, 8'h00, 1'b0};
        tab[24] = '{1'b0, 5'b00000, 8'h00, 1'b0};
        tab[25] = '{1'b0, 5'b00010, 8'h3F, 1'b0};
        tab[26] = '{1'b0, 5'b00010, 8'h3F, 1'b0};
        tab[27] = '{1'b0, 5'b00010, 8'h3F, 1'b0};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = 3'd0;
        wr_data = 4'd0;
        commit  = 1'b0;
        blank   = 1'b0;
        modelReset();

        // Reset state
        repeat (3) @(negedge clk);
        cmp("reset.slct",  {3'b000, dgt_slct}, 8'h00);
        cmp("reset.data",  data_out,           8'h00);
        cmp("reset.frame", {7'd0, frame_done}, 8'h00);
        cmp("reset.rdy",   {7'd0, wr_rdy},     8'h01);
        rst_n = 1'b1;

        // Scan sequence after reset, with a blank stretch in the second frame
        $display("[TB] table vectors");
        for (int i = 0; i < 28; i++) begin
            logic [7:0] exp_data;
            applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, tab[i].blank);
            exp_data = tab[i].data;
`ifdef SEG_LZB_EN
            if (tab[i].slct > 5'b00001) exp_data = 8'h00;
`endif
            cmp($sformatf("tab%0d.slct", i),  {3'b000, dgt_slct}, {3'b000, tab[i].slct});
            cmp($sformatf("tab%0d.data", i),  data_out,           exp_data);
            cmp($sformatf("tab%0d.frame", i), {7'd0, frame_done}, {7'd0, tab[i].frame});
            cmp($sformatf("tab%0d.rdy", i),   {7'd0, wr_rdy},     8'h01);
        end

        // Shadow writes without commit leave the display untouched
        $display("[TB] shadow writes, no commit");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(i), 4'(i + 1), 1'b0, 1'b0);
            checkOutput("wr_nocommit");
        end
        idle(60, "nocommit");

        // Commit mid-frame; interface closed until the frame boundary
        $display("[TB] commit mid-frame");
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("commit");
        cmp("commit.rdy_low", {7'd0, wr_rdy}, 8'h00);
        applyStimulus(1'b1, 3'd0, 4'd9, 1'b1, 1'b0);
        checkOutput("wr_while_pend");
        waitRdy("commit1");
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        cmp("newframe.ghost", {3'b000, dgt_slct}, 8'h00);
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        cmp("newframe.slct0", {3'b000, dgt_slct}, 8'h01);
        cmp("newframe.data0", data_out,           8'h06);
        idle(22, "after_commit1");

        // Invalid code on digit 2, out-of-range index ignored, write+commit together
        $display("[TB] invalid BCD and idx 6");
        applyStimulus(1'b1, 3'd6, 4'd8, 1'b0, 1'b0);
        checkOutput("wr_idx6");
        applyStimulus(1'b1, 3'd2, 4'hC, 1'b1, 1'b0);
        checkOutput("wr_commit");
        waitRdy("commit2");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
            checkOutput("bcdC");
        end
        cmp("bcdC.slct2", {3'b000, dgt_slct}, 8'h04);
        cmp("bcdC.data2", data_out,           8'h00);
        idle(12, "after_commit2");

        // Leading-zero pattern committed while blanked across the boundary
        $display("[TB] blank with commit 0,0,7,0,0");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(i), (i == 2) ? 4'd7 : 4'd0, 1'b0, 1'b1);
            checkOutput("lz_wr");
        end
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 1'b1);
        checkOutput("lz_commit");
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
            checkOutput("blanked");
        end
        idle(40, "lz_show");

        // Reset while a commit is pending
        $display("[TB] reset during pending commit");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(i), 4'd8, 1'b0, 1'b0);
            checkOutput("pre_rst_wr");
        end
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("pre_rst_commit");
        idle(2, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst.slct",  {3'b000, dgt_slct}, 8'h00);
        cmp("async_rst.data",  data_out,           8'h00);
        cmp("async_rst.frame", {7'd0, frame_done}, 8'h00);
        cmp("async_rst.rdy",   {7'd0, wr_rdy},     8'h01);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(45, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
